// File: rtl/decimal_entry_pkg.sv
// Shared types and helpers for the push-button decimal entry block.
package decimal_entry_pkg;

    localparam int BCD_W   = 4;
    localparam int NUM_BTN = 5;

    // Bit positions in the packed button/event vector.
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_ENTER = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] d);
        return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
    endfunction

endpackage

// File: rtl/decimal_entry_button_debounce.sv
// Synchronises one raw button and debounces it; press is a one-cycle pulse on
// the released-to-pressed transition of the debounced state.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic state,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync  <= '0;
            cnt   <= '0;
            state <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == state) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                state <= ~state;
                press <= ~state;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/decimal_entry.sv
// Button-driven BCD editor with a cursor; on enter, converts the digits to a
// saturated binary value using a shift-add multiply-by-10 accumulator.
module decimal_entry
    import decimal_entry_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DIGITS          = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_enter,
    output logic [BCD_W*DIGITS-1:0] digits_bcd,
    output logic [DIGITS-1:0]       cursor,
    output logic                    busy,
    output logic                    valid,
    output logic [WIDTH-1:0]        value,
    output logic                    overflow
);

    localparam int ACC_W = $clog2(10 ** DIGITS);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [NUM_BTN-1:0] raw, btn_state, press, events;

    assign raw = {btn_enter, btn_right, btn_left, btn_down, btn_up};

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clock (clock),
            .reset (reset),
            .raw   (raw[b]),
            .state (btn_state[b]),
            .press (press[b])
        );
    end

    assign events = press & btn_state;

    state_t state, state_next;

    logic [ACC_W-1:0]        acc, acc_next;
    logic [IDX_W-1:0]        idx;
    logic [BCD_W-1:0]        cur_digit;
    logic [BCD_W*DIGITS-1:0] digits_up, digits_dn;
    logic                    ovf_next;
    logic [WIDTH-1:0]        sat_value;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (events[BTN_ENTER]) state_next = CONVERT;
            CONVERT: if (idx == '0)         state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        valid = (state == DONE);
    end

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++)
            if (idx == IDX_W'(i)) cur_digit = digits_bcd[i*BCD_W +: BCD_W];
        acc_next  = (acc << 3) + (acc << 1) + ACC_W'(cur_digit);
        ovf_next  = (acc_next >> WIDTH) != '0;
        sat_value = ovf_next ? '1 : WIDTH'(acc_next);
    end

    always_comb begin
        digits_up = digits_bcd;
        digits_dn = digits_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (cursor[i]) begin
                digits_up[i*BCD_W +: BCD_W] = bcd_inc(digits_bcd[i*BCD_W +: BCD_W]);
                digits_dn[i*BCD_W +: BCD_W] = bcd_dec(digits_bcd[i*BCD_W +: BCD_W]);
            end
        end
    end

    // The result is loaded as the last digit is accumulated so it is already
    // visible in the cycle that valid pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digits_bcd <= '0;
            cursor     <= DIGITS'(1);
            acc        <= '0;
            idx        <= '0;
            value      <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (events[BTN_ENTER]) begin
                        acc <= '0;
                        idx <= IDX_W'(DIGITS - 1);
                    end else if (events[BTN_UP]) begin
                        digits_bcd <= digits_up;
                    end else if (events[BTN_DOWN]) begin
                        digits_bcd <= digits_dn;
                    end else if (events[BTN_LEFT]) begin
                        cursor <= {cursor[DIGITS-2:0], cursor[DIGITS-1]};
                    end else if (events[BTN_RIGHT]) begin
                        cursor <= {cursor[0], cursor[DIGITS-1:1]};
                    end
                end
                CONVERT: begin
                    acc <= acc_next;
                    idx <= idx - IDX_W'(1);
                    if (idx == '0) begin
                        value    <= sat_value;
                        overflow <= ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decimal_entry.sv
// Self-checking bench: edits are checked against a digit/cursor model, and
// conversion results are queued on enter and compared when valid pulses.
`timescale 1ns/1ps
module tb_decimal_entry;

    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_ENTER = 4;

    typedef struct {
        logic [7:0] value;
        logic       ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  btn;
    logic [11:0] digits_bcd;
    logic [2:0]  cursor;
    logic        busy, valid, overflow;
    logic [7:0]  value;

    int total = 0;
    int bad   = 0;

    exp_t       sb[$];
    logic [3:0] model_d[3];
    int         model_cur;

    always #5 clk = ~clk;

    decimal_entry #(.WIDTH(8), .DIGITS(3), .DEBOUNCE_CYCLES(4)) dut (
        .clock      (clk),
        .reset      (rst_n),
        .btn_up     (btn[B_UP]),
        .btn_down   (btn[B_DOWN]),
        .btn_left   (btn[B_LEFT]),
        .btn_right  (btn[B_RIGHT]),
        .btn_enter  (btn[B_ENTER]),
        .digits_bcd (digits_bcd),
        .cursor     (cursor),
        .busy       (busy),
        .valid      (valid),
        .value      (value),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] exp_digits();
        return {model_d[2], model_d[1], model_d[0]};
    endfunction

    function automatic logic [2:0] exp_cursor();
        return 3'(1 << model_cur);
    endfunction

    task automatic apply_model(input int b);
        case (b)
            B_UP:    model_d[model_cur] = (model_d[model_cur] == 4'd9) ? 4'd0 : model_d[model_cur] + 4'd1;
            B_DOWN:  model_d[model_cur] = (model_d[model_cur] == 4'd0) ? 4'd9 : model_d[model_cur] - 4'd1;
            B_LEFT:  model_cur = (model_cur + 1) % 3;
            B_RIGHT: model_cur = (model_cur + 2) % 3;
            default: ;
        endcase
    endtask

    task automatic push_expected();
        int   n;
        exp_t e;
        n     = model_d[2] * 100 + model_d[1] * 10 + model_d[0];
        e.ovf   = (n > 255);
        e.value = e.ovf ? 8'hFF : 8'(n);
        sb.push_back(e);
    endtask

    task automatic check_edit(input string tag);
        check({tag, "_digits"}, digits_bcd, exp_digits());
        check({tag, "_cursor"}, cursor, exp_cursor());
    endtask

    task automatic press(input int b);
        if (b == B_ENTER) push_expected();
        btn[b] = 1'b1;
        tick(12);
        btn[b] = 1'b0;
        tick(12);
        apply_model(b);
    endtask

    task automatic goto(input int pos);
        while (model_cur != pos) press(B_LEFT);
    endtask

    task automatic set_digit(input logic [3:0] v);
        while (model_d[model_cur] != v) press(B_UP);
    endtask

    task automatic load_and_convert(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
        goto(2); set_digit(d2);
        goto(1); set_digit(d1);
        goto(0); set_digit(d0);
        check_edit("load");
        press(B_ENTER);
    endtask

    // Conversion monitor: busy length, valid position and result scoreboard.
    int   busy_cnt = 0;
    exp_t got_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (valid) begin
                check("valid_pos", busy_cnt, 4);
                check("sb_pending", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    got_exp = sb.pop_front();
                    check("value", value, got_exp.value);
                    check("overflow", overflow, got_exp.ovf);
                end
            end
            if (!busy && busy_cnt != 0) begin
                check("busy_len", busy_cnt, 4);
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_n;
        btn   = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) model_d[i] = 4'd0;
        model_cur = 0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_digits", digits_bcd, 12'h000);
        check("rst_cursor", cursor, 3'b001);
        check("rst_value", value, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        // Bouncing input: levels last 2 cycles, shorter than the filter.
        for (int i = 0; i < 10; i++) begin
            btn[B_UP] = 1'b1; tick(2);
            btn[B_UP] = 1'b0; tick(2);
        end
        check("bounce_quiet", digits_bcd, 12'h000);
        btn[B_UP] = 1'b1;
        tick(10);
        apply_model(B_UP);
        check_edit("bounce");
        tick(100);
        check_edit("held");
        btn[B_UP] = 1'b0;
        tick(12);
        check_edit("release");

        // Digit and cursor wrap-around.
        press(B_DOWN);
        check_edit("down_to0");
        for (int i = 0; i < 10; i++) press(B_UP);
        check_edit("up10");
        press(B_DOWN);
        check_edit("down_wrap");
        check("down_wrap_lsd", digits_bcd[3:0], 4'd9);
        press(B_LEFT);
        press(B_LEFT);
        check("cursor_msd", cursor, 3'b100);
        press(B_LEFT);
        check("left_wrap", cursor, 3'b001);
        press(B_RIGHT);
        check("right_wrap", cursor, 3'b100);

        // Conversion with an up event arriving while busy.
        goto(2); set_digit(4'd2);
        goto(1); set_digit(4'd5);
        goto(0); set_digit(4'd5);
        push_expected();
        btn[B_ENTER] = 1'b1;
        tick(2);
        btn[B_UP] = 1'b1;
        tick(12);
        btn = '0;
        tick(12);
        check_edit("busy_drop");
        check("conv255_value", value, 8'hFF);
        check("conv255_ovf", overflow, 1'b0);

        load_and_convert(4'd2, 4'd5, 4'd6);
        check("conv256_ovf", overflow, 1'b1);
        load_and_convert(4'd9, 4'd9, 4'd9);
        check("conv999_value", value, 8'hFF);
        load_and_convert(4'd0, 4'd4, 4'd2);
        check("conv042_value", value, 8'h2A);
        check("conv042_ovf", overflow, 1'b0);
        check_edit("hold_after_conv");

        // Simultaneous up and right: priority keeps only the increment.
        btn[B_UP]    = 1'b1;
        btn[B_RIGHT] = 1'b1;
        tick(12);
        btn = '0;
        tick(12);
        apply_model(B_UP);
        check_edit("simul");
        check("simul_value_hold", value, 8'h2A);

        // Reset during a conversion.
        push_expected();
        btn[B_ENTER] = 1'b1;
        wait_n = 0;
        while (!busy && wait_n < 30) begin
            tick(1);
            wait_n++;
        end
        check("abort_busy_seen", busy, 1'b1);
        tick(1);
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) model_d[i] = 4'd0;
        model_cur = 0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", valid, 1'b0);
        check("abort_value", value, 8'h00);
        check("abort_overflow", overflow, 1'b0);
        btn = '0;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check_edit("abort_edit");
        check("abort_value_after", value, 8'h00);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
